// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter sharing one single-port L2 bank among N_MASTERS requesters; L2_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
// Latency: grant is combinational in the request cycle; r_valid and read data follow one cycle later.
// Backpressure: a master that is not granted holds its req and payload; the bank serves one access per cycle without bubbles.
module l2_bank_arbiter #(
   parameter int N_MASTERS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20,
   parameter int BE_WIDTH   = DATA_WIDTH/8,
   parameter int ID_WIDTH   = $clog2(N_MASTERS)
) (
   input  logic                             CLK,
   input  logic                             RSTN,
   input  logic [N_MASTERS-1:0]             data_req_i,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  data_add_i,
   input  logic [N_MASTERS-1:0]             data_wen_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]  data_wdata_i,
   input  logic [N_MASTERS*BE_WIDTH-1:0]    data_be_i,
   output logic [N_MASTERS-1:0]             data_gnt_o,
   output logic [N_MASTERS-1:0]             data_r_valid_o,
   output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
   output logic                             mem_cen_o,
   output logic                             mem_wen_o,
   output logic [ADDR_WIDTH-1:0]            mem_a_o,
   output logic [DATA_WIDTH-1:0]            mem_d_o,
   output logic [BE_WIDTH-1:0]              mem_be_o,
   output logic [ID_WIDTH-1:0]              mem_id_o,
   input  logic [DATA_WIDTH-1:0]            mem_q_i,
   input  logic [ID_WIDTH-1:0]              mem_r_id_i,
   input  logic                             mem_r_valid_i,
   output logic                             err_o
);

   logic                win_vld;
   logic [ID_WIDTH-1:0] win_idx;
   logic                pend_v_q;
   logic [ID_WIDTH-1:0] pend_id_q;
`ifndef L2_ARB_FIXED_PRIO_EN
   logic [ID_WIDTH-1:0] rr_ptr_q;
`endif

   // Search starts at the pointer and wraps explicitly, so non-power-of-two counts work.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int j = 0; j < N_MASTERS; j++) begin
`ifdef L2_ARB_FIXED_PRIO_EN
         idx = j;
`else
         idx = int'(rr_ptr_q) + j;
         if (idx >= N_MASTERS) idx = idx - N_MASTERS;
`endif
         if (!win_vld && data_req_i[idx] && RSTN) begin
            win_vld = 1'b1;
            win_idx = ID_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      data_gnt_o = '0;
      mem_cen_o  = 1'b1;
      mem_wen_o  = 1'b0;
      mem_a_o    = '0;
      mem_d_o    = '0;
      mem_be_o   = '0;
      mem_id_o   = '0;
      if (win_vld) begin
         data_gnt_o[win_idx] = 1'b1;
         mem_cen_o           = 1'b0;
         mem_wen_o           = data_wen_i[win_idx];
         mem_a_o             = data_add_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
         mem_d_o             = data_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
         mem_be_o            = data_be_i[win_idx*BE_WIDTH +: BE_WIDTH];
         mem_id_o            = win_idx;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
`ifndef L2_ARB_FIXED_PRIO_EN
         rr_ptr_q  <= '0;
`endif
         pend_v_q  <= 1'b0;
         pend_id_q <= '0;
         err_o     <= 1'b0;
      end else begin
`ifndef L2_ARB_FIXED_PRIO_EN
         if (win_vld)
            rr_ptr_q <= (win_idx == ID_WIDTH'(N_MASTERS-1)) ? '0 : win_idx + 1'b1;
`endif
         pend_v_q  <= win_vld;
         pend_id_q <= win_idx;
         // Sticky: the bank must answer every access with the id we issued.
         if (pend_v_q && (!mem_r_valid_i || (mem_r_id_i != pend_id_q)))
            err_o <= 1'b1;
      end
   end

   always_comb begin
      data_r_valid_o = '0;
      if (pend_v_q) data_r_valid_o[pend_id_q] = 1'b1;
   end

   assign data_r_rdata_o = mem_q_i;

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed bench for l2_bank_arbiter with a one-cycle behavioural bank attached.
module tb_l2_bank_arbiter;
   localparam int N = 4, DW = 32, AW = 20, BW = 4, IW = 2;

   logic            CLK = 1'b0;
   logic            RSTN = 1'b0;
   logic [N-1:0]    data_req_i = '0;
   logic [N*AW-1:0] data_add_i = '0;
   logic [N-1:0]    data_wen_i = '1;
   logic [N*DW-1:0] data_wdata_i = '0;
   logic [N*BW-1:0] data_be_i = '0;
   logic [N-1:0]    data_gnt_o, data_r_valid_o;
   logic [DW-1:0]   data_r_rdata_o;
   logic            mem_cen_o, mem_wen_o, err_o;
   logic [AW-1:0]   mem_a_o;
   logic [DW-1:0]   mem_d_o;
   logic [BW-1:0]   mem_be_o;
   logic [IW-1:0]   mem_id_o;
   logic [DW-1:0]   mem_q_i = '0;
   logic [IW-1:0]   mem_r_id_i = '0;
   logic            mem_r_valid_i = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   logic corrupt = 1'b0;
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] bw;

   always #5 CLK = ~CLK;

   l2_bank_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
      .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
      .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_a_o(mem_a_o), .mem_d_o(mem_d_o),
      .mem_be_o(mem_be_o), .mem_id_o(mem_id_o), .mem_q_i(mem_q_i),
      .mem_r_id_i(mem_r_id_i), .mem_r_valid_i(mem_r_valid_i), .err_o(err_o)
   );

   // Behavioural bank: one-cycle read latency, byte-enabled writes, optional id corruption.
   always @(posedge CLK) begin
      if (!mem_cen_o) begin
         if (!mem_wen_o) begin
            bw = mem[mem_a_o[7:0]];
            for (int b = 0; b < BW; b++)
               if (mem_be_o[b]) bw[b*8 +: 8] = mem_d_o[b*8 +: 8];
            mem[mem_a_o[7:0]] <= bw;
         end else begin
            mem_q_i <= mem[mem_a_o[7:0]];
         end
         mem_r_id_i    <= corrupt ? 2'd1 : mem_id_o;
         mem_r_valid_i <= 1'b1;
      end else begin
         mem_r_valid_i <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_m(input int m, input logic req, input logic wen,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      data_req_i[m]             = req;
      data_wen_i[m]             = wen;
      data_add_i[m*AW +: AW]    = a;
      data_wdata_i[m*DW +: DW]  = d;
      data_be_i[m*BW +: BW]     = be;
   endtask

   task automatic set_req(input logic [N-1:0] r);
      for (int m = 0; m < N; m++) set_m(m, r[m], 1'b1, AW'(m), '0, '0);
   endtask

   // Check grant and r_valid for the current cycle, then advance.
   task automatic cyc(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ev);
      @(negedge CLK);
      chk({tag, "_gnt"}, 64'(data_gnt_o), 64'(eg));
      chk({tag, "_rv"}, 64'(data_r_valid_o), 64'(ev));
      tick();
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      set_req('0);
      tick();
      RSTN = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      // Reset state, with a request present that must not be granted.
      set_req(4'b0001);
      @(negedge CLK);
      chk("rst_gnt", 64'(data_gnt_o), 64'h0);
      chk("rst_cen", 64'(mem_cen_o), 64'h1);
      chk("rst_rv", 64'(data_r_valid_o), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      tick();
      RSTN = 1'b1;
      set_req('0);

      // Single write then read by M2.
      set_m(2, 1'b1, 1'b0, 20'h10, 32'hDEADBEEF, 4'hF);
      @(negedge CLK);
      chk("wr_gnt", 64'(data_gnt_o), 64'h4);
      chk("wr_cen", 64'(mem_cen_o), 64'h0);
      chk("wr_wen", 64'(mem_wen_o), 64'h0);
      chk("wr_a", 64'(mem_a_o), 64'h10);
      chk("wr_d", 64'(mem_d_o), 64'hDEADBEEF);
      chk("wr_id", 64'(mem_id_o), 64'h2);
      tick();
      set_m(2, 1'b1, 1'b1, 20'h10, '0, '0);
      @(negedge CLK);
      chk("rd_gnt", 64'(data_gnt_o), 64'h4);
      chk("rd_wen", 64'(mem_wen_o), 64'h1);
      chk("wr_rv", 64'(data_r_valid_o), 64'h4);
      tick();
      set_req('0);
      @(negedge CLK);
      chk("idle_cen", 64'(mem_cen_o), 64'h1);
      chk("rd_rv", 64'(data_r_valid_o), 64'h4);
      chk("rd_data", 64'(data_r_rdata_o), 64'hDEADBEEF);
      tick();
      cyc("rd_done", 4'b0000, 4'b0000);

`ifndef L2_ARB_FIXED_PRIO_EN
      // Full contention from reset: strict rotation, r_valid one cycle behind.
      do_reset();
      set_req(4'b1111);
      for (int i = 0; i < 8; i++)
         cyc($sformatf("rot%0d", i), 4'(1 << (i % 4)), (i == 0) ? 4'b0000 : 4'(1 << ((i - 1) % 4)));
      set_req('0);
      cyc("rot_tail", 4'b0000, 4'b1000);

      // Pointer wrap and skip: M1 alone moves the pointer to 2, then M3 and M1 compete.
      set_req(4'b0010);
      cyc("ptr_set", 4'b0010, 4'b0000);
      set_req(4'b1010);
      cyc("skip_m3", 4'b1000, 4'b0010);
      set_req(4'b0010);
      cyc("skip_m1", 4'b0010, 4'b1000);
      set_req(4'b1111);
      cyc("ptr_is2", 4'b0100, 4'b0010);
      set_req('0);
      cyc("ptr_tail", 4'b0000, 4'b0100);
`endif

      // Byte enables: partial overwrite by M1.
      set_req('0);
      set_m(0, 1'b1, 1'b0, 20'h4, 32'h11223344, 4'hF);
      cyc("be_w0", 4'b0001, 4'b0000);
      set_req('0);
      set_m(1, 1'b1, 1'b0, 20'h4, 32'hAABBCCDD, 4'b0011);
      cyc("be_w1", 4'b0010, 4'b0001);
      set_m(1, 1'b1, 1'b1, 20'h4, '0, '0);
      cyc("be_rd", 4'b0010, 4'b0010);
      set_req('0);
      @(negedge CLK);
      chk("be_rv", 64'(data_r_valid_o), 64'h2);
      chk("be_data", 64'(data_r_rdata_o), 64'h1122CCDD);
      tick();

      // Id mismatch sets a sticky error; reset with a grant in flight clears it.
      corrupt = 1'b1;
      set_m(2, 1'b1, 1'b1, 20'h10, '0, '0);
      @(negedge CLK);
      chk("mm_err0", 64'(err_o), 64'h0);
      tick();
      corrupt = 1'b0;
      set_req('0);
      @(negedge CLK);
      chk("mm_rv", 64'(data_r_valid_o), 64'h4);
      chk("mm_err1", 64'(err_o), 64'h0);
      tick();
      @(negedge CLK);
      chk("mm_err2", 64'(err_o), 64'h1);
      tick();
      @(negedge CLK);
      chk("mm_sticky", 64'(err_o), 64'h1);
      tick();
      set_req(4'b0001);
      cyc("mm_gnt", 4'b0001, 4'b0000);
      RSTN = 1'b0;
      @(negedge CLK);
      chk("mrst_err", 64'(err_o), 64'h0);
      chk("mrst_gnt", 64'(data_gnt_o), 64'h0);
      chk("mrst_cen", 64'(mem_cen_o), 64'h1);
      chk("mrst_rv", 64'(data_r_valid_o), 64'h0);
      tick();
      RSTN = 1'b1;
      set_req('0);
      cyc("post_rst0", 4'b0000, 4'b0000);
      cyc("post_rst1", 4'b0000, 4'b0000);

`ifdef L2_ARB_FIXED_PRIO_EN
      // Fixed priority: M0 starves M3.
      set_req(4'b1001);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("fix%0d", i), 4'b0001, (i == 0) ? 4'b0000 : 4'b0001);
      set_req('0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
